// File: rtl/fetch_ifid.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Drives imem from the PC and handles stalls, redirect/flush and a terminal halt.
module fetch_ifid #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write_en,
    input  logic        ifid_write_en,
    input  logic        pc_src,
    input  logic [15:0] branch_target,
    input  logic        halt,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_err,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_inc,
    output logic        ifid_valid,
    output logic        fetch_err,
    output logic        halted
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcinc_q, pcinc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [15:0] pc_inc;

    assign pc_inc    = pc_q + 16'd2;
    assign imem_addr = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcinc_d = pcinc_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (state_q == RUN) begin
            if (halt || imem_err) begin
                state_d = HALTED;
                instr_d = NOP_INSTR;
                pcinc_d = 16'h0000;
                valid_d = 1'b0;
                err_d   = err_q | imem_err;
            end else if (pc_src && ifid_write_en) begin
                // redirect wins over a PC stall; the wrong-path fetch becomes one bubble
                pc_d    = branch_target;
                instr_d = NOP_INSTR;
                pcinc_d = 16'h0000;
                valid_d = 1'b0;
            end else begin
                if (pc_write_en) pc_d = pc_inc;
                if (ifid_write_en) begin
                    instr_d = imem_data;
                    pcinc_d = pc_inc;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcinc_q <= 16'h0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcinc_q <= pcinc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign ifid_instr  = instr_q;
    assign ifid_pc_inc = pcinc_q;
    assign ifid_valid  = valid_q;
    assign fetch_err   = err_q;
    assign halted      = (state_q == HALTED);

    // The hazard unit must never advance the PC while holding IF/ID.
    a_no_pc_without_ifid: assert property (@(posedge clk) disable iff (!rst)
        (state_q == RUN) |-> !(pc_write_en && !ifid_write_en));

endmodule
